// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and uart_tx-side signals of the byte arbiter.
// The arbiter uses the slave modport; the surrounding system drives through master.
interface uart_tx_arbiter_if;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  ack;
   logic [3:0]  grant;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic        arb_busy;
   logic        lock_timeout;

   modport slave (
      input  req, req_data, req_last, tx_busy,
      output ack, grant, tx_start, tx_data, arb_busy, lock_timeout
   );

   modport master (
      output req, req_data, req_last, tx_busy,
      input  ack, grant, tx_start, tx_data, arb_busy, lock_timeout
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one uart_tx from four byte requesters.
// A message (bytes up to req_last) keeps ownership until it ends or the lock idles out.
module uart_tx_arbiter #(
   parameter int N_REQ        = 4,
   parameter int LOCK_TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   uart_tx_arbiter_if.slave  bus
);
   localparam int TW = $clog2(LOCK_TIMEOUT) + 1;

   typedef enum logic [1:0] {IDLE, LAUNCH, SEND, HOLD} state_t;

   state_t        state_q, state_d;
   logic [3:0]    grant_q, grant_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          lock_q, lock_d;
   logic          started_q, started_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [1:0]    rr_ptr_q, rr_ptr_d;
   logic [1:0]    owner_q, owner_d;
   logic [3:0]    ack_d;
   logic          tx_start_d;
   logic          lock_timeout_d;
   logic [1:0]    winner;
   logic [7:0]    req_byte [N_REQ];

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_byte
      assign req_byte[gi] = bus.req_data[8*gi +: 8];
   end

   // Scan downward so the closest requester after rr_ptr is the last to win.
   always_comb begin
      winner = rr_ptr_q;
      for (int k = N_REQ; k >= 1; k--) begin
         if (bus.req[2'(rr_ptr_q + 2'(k))]) winner = 2'(rr_ptr_q + 2'(k));
      end
   end

   always_comb begin
      state_d        = state_q;
      grant_d        = grant_q;
      tx_data_d      = tx_data_q;
      lock_d         = lock_q;
      started_d      = started_q;
      timer_d        = timer_q;
      rr_ptr_d       = rr_ptr_q;
      owner_d        = owner_q;
      ack_d          = 4'b0000;
      tx_start_d     = 1'b0;
      lock_timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req != 4'b0000) begin
               grant_d   = 4'b0001 << winner;
               ack_d     = 4'b0001 << winner;
               owner_d   = winner;
               tx_data_d = req_byte[winner];
               lock_d    = ~bus.req_last[winner];
               started_d = 1'b0;
               state_d   = LAUNCH;
            end
         end
         LAUNCH: begin
            // started_q keeps a busy-on-entry uart from being mistaken for our own launch.
            if (!started_q && !bus.tx_busy) begin
               tx_start_d = 1'b1;
               started_d  = 1'b1;
            end else if (started_q && bus.tx_busy) begin
               state_d = SEND;
            end
         end
         SEND: begin
            if (!bus.tx_busy) begin
               if (lock_q) begin
                  timer_d = '0;
                  state_d = HOLD;
               end else begin
                  grant_d  = 4'b0000;
                  rr_ptr_d = owner_q;
                  state_d  = IDLE;
               end
            end
         end
         HOLD: begin
            if (bus.req[owner_q]) begin
               ack_d     = 4'b0001 << owner_q;
               tx_data_d = req_byte[owner_q];
               lock_d    = ~bus.req_last[owner_q];
               timer_d   = '0;
               started_d = 1'b0;
               state_d   = LAUNCH;
            end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
               grant_d        = 4'b0000;
               rr_ptr_d       = owner_q;
               lock_d         = 1'b0;
               timer_d        = '0;
               lock_timeout_d = 1'b1;
               state_d        = IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         grant_q   <= 4'b0000;
         tx_data_q <= 8'h00;
         lock_q    <= 1'b0;
         started_q <= 1'b0;
         timer_q   <= '0;
         rr_ptr_q  <= 2'd3;
         owner_q   <= 2'd0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         tx_data_q <= tx_data_d;
         lock_q    <= lock_d;
         started_q <= started_d;
         timer_q   <= timer_d;
         rr_ptr_q  <= rr_ptr_d;
         owner_q   <= owner_d;
      end
   end

   assign bus.ack          = rst ? 4'b0000 : ack_d;
   assign bus.tx_start     = tx_start_d & ~rst;
   assign bus.lock_timeout = lock_timeout_d & ~rst;
   assign bus.grant        = grant_q;
   assign bus.tx_data      = tx_data_q;
   assign bus.arb_busy     = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed checks of uart_tx_arbiter against a small behavioural uart_tx.
// Inputs change 1ns after the falling edge; outputs are checked 1ns later.
module tb_uart_tx_arbiter;
   localparam int BUSY_LEN = 3;

   logic clk        = 1'b0;
   logic rst        = 1'b1;
   logic force_busy = 1'b0;
   int   busy_cnt   = 0;
   int   start_cnt  = 0;
   int   lt_cnt     = 0;
   int   ack_multi  = 0;
   int   errors     = 0;
   int   checks     = 0;
   logic [7:0] sent [$];
   logic [3:0] ack_log [$];

   uart_tx_arbiter_if bus ();

   uart_tx_arbiter #(.N_REQ(4), .LOCK_TIMEOUT(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.tx_busy = (busy_cnt != 0) || force_busy;

   // uart_tx stand-in: samples late in the cycle, updates just after the rising edge.
   always begin : uart_model
      logic       go, r, lt;
      logic [7:0] dat;
      logic [3:0] a;
      @(negedge clk);
      #3;
      go  = bus.tx_start;
      dat = bus.tx_data;
      a   = bus.ack;
      lt  = bus.lock_timeout;
      r   = rst;
      @(posedge clk);
      #1;
      if (r) begin
         busy_cnt = 0;
      end else begin
         if (busy_cnt != 0) busy_cnt--;
         if (go) begin
            busy_cnt = BUSY_LEN;
            sent.push_back(dat);
            start_cnt++;
         end
         if (a != 4'b0000) begin
            ack_log.push_back(a);
            if (!$onehot(a)) ack_multi++;
         end
         if (lt) lt_cnt++;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      force_busy   = 1'b0;
      bus.req      = 4'b0000;
      bus.req_last = 4'b0000;
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (bus.arb_busy && n < 200) begin
         tick();
         n++;
      end
      chk(tag, bus.arb_busy, 1'b0);
   endtask

   initial begin : stim
      logic [7:0] exp_b [5];
      logic [3:0] exp_a [5];
      logic [7:0] lk_b [3];
      logic [7:0] lk_exp [4];
      logic [3:0] lk_ack [4];
      int n, k, s0;

      bus.req      = 4'b0000;
      bus.req_data = 32'h0;
      bus.req_last = 4'b0000;
      tick();
      tick();
      do_reset();

      // Reset state
      chk("rst_grant", bus.grant, 4'b0000);
      chk("rst_ack", bus.ack, 4'b0000);
      chk("rst_tx_start", bus.tx_start, 1'b0);
      chk("rst_tx_data", bus.tx_data, 8'h00);
      chk("rst_arb_busy", bus.arb_busy, 1'b0);
      chk("rst_lock_timeout", bus.lock_timeout, 1'b0);
      $display("reset: grant=%b ack=%b arb_busy=%b", bus.grant, bus.ack, bus.arb_busy);

      // Single byte from requester 0
      bus.req      = 4'b0001;
      bus.req_data = 32'h0000_00A5;
      bus.req_last = 4'b1111;
      #1;
      chk("single_ack", bus.ack, 4'b0001);
      tick();
      bus.req      = 4'b0000;
      bus.req_data = 32'h0000_003C;
      #1;
      chk("single_ack_pulse", bus.ack, 4'b0000);
      chk("single_grant", bus.grant, 4'b0001);
      chk("single_tx_start", bus.tx_start, 1'b1);
      chk("single_tx_data", bus.tx_data, 8'hA5);
      chk("single_arb_busy", bus.arb_busy, 1'b1);
      wait_idle("single_idle");
      chk("single_grant_released", bus.grant, 4'b0000);
      chk("single_tx_data_held", bus.tx_data, 8'hA5);
      chk("single_starts", start_cnt, 1);
      chk("single_sent", sent[0], 8'hA5);
      chk("single_acks", ack_log.size(), 1);
      $display("single: sent=%0h starts=%0d", sent[0], start_cnt);

      // Contention, all requesters held with last=1
      do_reset();
      sent.delete();
      ack_log.delete();
      bus.req      = 4'b1111;
      bus.req_data = 32'hB3B2_B1B0;
      bus.req_last = 4'b1111;
      n = 0;
      while (sent.size() < 5 && n < 300) begin
         tick();
         n++;
      end
      bus.req = 4'b0000;
      wait_idle("rr_idle");
      exp_b = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB0};
      exp_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      chk("rr_ack_count", ack_log.size(), 5);
      for (int i = 0; i < 5; i++) begin
         chk("rr_byte", sent[i], exp_b[i]);
         chk("rr_ack", ack_log[i], exp_a[i]);
         $display("rr: byte %0d = %0h ack=%b", i, sent[i], ack_log[i]);
      end

      // Locked message from requester 0 while requester 2 waits
      do_reset();
      sent.delete();
      ack_log.delete();
      lk_b         = '{8'h11, 8'h22, 8'h33};
      bus.req      = 4'b0101;
      bus.req_data = 32'h00EE_0011;
      bus.req_last = 4'b0100;
      #1;
      for (int b = 0; b < 3; b++) begin
         n = 0;
         while (bus.ack[0] !== 1'b1 && n < 100) begin
            tick();
            n++;
         end
         chk("lock_ack0", bus.ack, 4'b0001);
         tick();
         if (b < 2) begin
            bus.req_data[7:0] = lk_b[b+1];
            bus.req_last[0]   = (b + 1 == 2);
         end else begin
            bus.req[0] = 1'b0;
         end
         #1;
      end
      n = 0;
      while (bus.ack[2] !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      chk("lock_ack2", bus.ack, 4'b0100);
      tick();
      bus.req = 4'b0000;
      wait_idle("lock_idle");
      lk_exp = '{8'h11, 8'h22, 8'h33, 8'hEE};
      lk_ack = '{4'b0001, 4'b0001, 4'b0001, 4'b0100};
      chk("lock_count", sent.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk("lock_byte", sent[i], lk_exp[i]);
         chk("lock_ack_order", ack_log[i], lk_ack[i]);
         $display("lock: byte %0d = %0h ack=%b", i, sent[i], ack_log[i]);
      end

      // Lock timeout, requester 1 pending
      do_reset();
      sent.delete();
      lt_cnt       = 0;
      bus.req      = 4'b0011;
      bus.req_data = 32'h0000_775A;
      bus.req_last = 4'b0010;
      #1;
      chk("to_ack0", bus.ack, 4'b0001);
      tick();
      bus.req = 4'b0010;
      #1;
      chk("to_tx_start", bus.tx_start, 1'b1);
      tick();
      n = 0;
      while (bus.tx_busy && n < 50) begin
         tick();
         n++;
      end
      k = 0;
      while (!bus.lock_timeout && k < 50) begin
         tick();
         k++;
      end
      chk("to_delay", k, 8);
      chk("to_grant_held", bus.grant, 4'b0001);
      chk("to_others_ignored", bus.ack, 4'b0000);
      tick();
      chk("to_grant_released", bus.grant, 4'b0000);
      chk("to_pulse_width", bus.lock_timeout, 1'b0);
      chk("to_ack1", bus.ack, 4'b0010);
      tick();
      bus.req = 4'b0000;
      #1;
      chk("to_grant1", bus.grant, 4'b0010);
      wait_idle("to_idle");
      chk("to_pulses", lt_cnt, 1);
      chk("to_byte0", sent[0], 8'h5A);
      chk("to_byte1", sent[1], 8'h77);
      $display("timeout: delay=%0d pulses=%0d bytes=%0h,%0h", k, lt_cnt, sent[0], sent[1]);

      // uart_tx already busy when LAUNCH is entered
      do_reset();
      sent.delete();
      force_busy   = 1'b1;
      bus.req      = 4'b1000;
      bus.req_data = 32'hC300_0000;
      bus.req_last = 4'b1111;
      #1;
      chk("busy_ack3", bus.ack, 4'b1000);
      tick();
      bus.req = 4'b0000;
      s0      = start_cnt;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("busy_no_start", bus.tx_start, 1'b0);
         tick();
      end
      force_busy = 1'b0;
      #1;
      chk("busy_start", bus.tx_start, 1'b1);
      tick();
      chk("busy_start_pulse", bus.tx_start, 1'b0);
      wait_idle("busy_idle");
      chk("busy_starts", start_cnt - s0, 1);
      chk("busy_byte", sent[0], 8'hC3);
      $display("busy: starts=%0d byte=%0h", start_cnt - s0, sent[0]);

      // Reset while SEND holds a lock
      do_reset();
      sent.delete();
      bus.req      = 4'b0001;
      bus.req_data = 32'h0000_0099;
      bus.req_last = 4'b0000;
      tick();
      bus.req = 4'b0000;
      #1;
      n = 0;
      while (!bus.tx_busy && n < 50) begin
         tick();
         n++;
      end
      tick();
      chk("mid_arb_busy", bus.arb_busy, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("mid_grant", bus.grant, 4'b0000);
      chk("mid_ack", bus.ack, 4'b0000);
      chk("mid_tx_start", bus.tx_start, 1'b0);
      chk("mid_tx_data", bus.tx_data, 8'h00);
      chk("mid_arb_busy_clr", bus.arb_busy, 1'b0);
      chk("mid_lock_timeout", bus.lock_timeout, 1'b0);
      sent.delete();
      bus.req      = 4'b1000;
      bus.req_data = 32'hD300_0000;
      bus.req_last = 4'b1000;
      #1;
      chk("mid_ack3", bus.ack, 4'b1000);
      tick();
      bus.req = 4'b0000;
      #1;
      chk("mid_grant3", bus.grant, 4'b1000);
      wait_idle("mid_idle");
      chk("mid_byte", sent[0], 8'hD3);
      chk("mid_grant_released", bus.grant, 4'b0000);
      $display("reset_mid: byte=%0h grant=%b", sent[0], bus.grant);

      chk("ack_onehot", ack_multi, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters (fixed; all widths below assume 4).
REQ-002 Parameter: LOCK_TIMEOUT, 1024, clk cycles a locked owner may idle in HOLD before lock release.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  4  req[i]=1: requester i presents a byte.
REQ-006 req_data  input  32  byte of requester i on [8i+7:8i].
REQ-007 req_last  input  4  req_last[i]=1: presented byte ends requester i's message.
REQ-008 ack  output  4  one-cycle pulse, byte of requester i captured.
REQ-009 grant  output  4  one-hot current owner; 0 in IDLE.
REQ-010 tx_start  output  1  launch strobe to uart_tx.
REQ-011 tx_data  output  8  byte to uart_tx, registered.
REQ-012 tx_busy  input  1  busy flag from uart_tx.
REQ-013 arb_busy  output  1  1 whenever state != IDLE.
REQ-014 lock_timeout  output  1  one-cycle pulse when a lock is released by timeout.

Function
REQ-015 FSM states: IDLE, LAUNCH, SEND, HOLD; state register only, outputs decoded/registered as stated.
REQ-016 IDLE: if any req, winner = first set bit scanning rr_ptr+1, rr_ptr+2, ... mod 4; same cycle: grant<=onehot(winner), tx_data<=req_data[winner], ack[winner] pulse, lock<=~req_last[winner], -> LAUNCH.
REQ-017 IDLE with req==0: stay; grant, ack, tx_start = 0.
REQ-018 LAUNCH: tx_start = (state==LAUNCH) && !tx_busy, combinational; -> SEND on first cycle tx_busy==1 is sampled.
REQ-019 tx_start high for exactly one cycle per byte when uart_tx idle; if tx_busy already high on LAUNCH entry, tx_start stays 0 until it falls.
REQ-020 SEND: wait for tx_busy==0; then lock==1 -> HOLD (timer cleared), lock==0 -> IDLE, grant<=0, rr_ptr<=owner.
REQ-021 HOLD: only owner serviced; req from others ignored; grant held.
REQ-022 HOLD with req[owner]==1: capture byte, ack pulse, lock<=~req_last[owner], timer cleared, -> LAUNCH.
REQ-023 HOLD without req[owner]: timer increments; at timer==LOCK_TIMEOUT-1 -> IDLE, grant<=0, rr_ptr<=owner, lock_timeout pulse.
REQ-024 Timer width ceil(log2(LOCK_TIMEOUT))+1 bits; no wrap before release.
REQ-025 At most one ack bit set per cycle; ack only in IDLE or HOLD capture cycles; continuously held req yields one ack per byte.
REQ-026 Simultaneous req in IDLE: round-robin only; rr_ptr updated solely on release, so a message owner is never preempted.
REQ-027 req_data / req_last sampled only in the ack cycle; later changes do not affect tx_data.
REQ-028 tx_data stable from capture until next capture.

Reset
REQ-029 rst=1 at rising edge: state IDLE, grant=0, ack=0, tx_data=8'h00, lock=0, timer=0, lock_timeout=0, rr_ptr=3 (requester 0 highest priority first), tx_start=0, arb_busy=0.
REQ-030 Reset mid-message (any state) abandons in-flight byte and lock; no ack or tx_start in the cycle after rst deasserts unless IDLE arbitration fires.
REQ-031 rst shared with uart_tx; no assumption of uart_tx state beyond tx_busy.

Verification
REQ-032 Single byte: req=4'b0001, data0=8'hA5, last0=1 -> ack=0001 one cycle, one tx_start, tx_data=A5, grant 0 after tx_busy falls.
REQ-033 Contention: req=4'b1111 held, all last=1 -> service order 0,1,2,3,0; exactly one ack per byte.
REQ-034 Lock: req0 sends 3 bytes 11,22,33 (last only on 33) while req2 asserted -> 11,22,33 transmitted before req2's byte.
REQ-035 Timeout: LOCK_TIMEOUT=8, req0 byte with last=0 then req0 dropped -> after SEND, lock_timeout pulses 8 cycles into HOLD, grant=0, pending req1 served next.
REQ-036 Busy at launch: tx_busy forced 1 on LAUNCH entry -> tx_start stays 0 until tx_busy low, then one pulse.
REQ-037 Reset during SEND with lock=1 -> all outputs at reset values next cycle; next req3 byte arbitrated normally.
